i2c_host_master: RTL and testbench
==================================

# i2c_host_master

Single-byte I2C bus master that drives `sck`/`sda` into the DRAM I2C slave at device address 0xA2/0xA3, letting on-chip logic write or read one DRAM byte over the bus. It performs one transaction per request:
- Write: START, 0xA2, index, data, STOP.
- Read: START, 0xA2, index, repeated START, 0xA3, data with master NACK, STOP.

It sits directly upstream of DRAM on the same `gclk` domain. It also supplies DRAM's `iicing` port mux select.

## Interface
Parameters:
- `CLK_DIV`, 50: `gclk` cycles per quarter SCL bit slot. Legal range is 4..1023.
- `DEV_ADDR`, 7'h51: 7-bit slave address. The write byte is {DEV_ADDR,0} = 0xA2 and the read byte is {DEV_ADDR,1} = 0xA3.

Ports:
- `gclk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse. Sampled only in IDLE.
- `rw`  in  1  0 = write, 1 = read. Latched with `start`.
- `addr`  in  8  DRAM index. Latched with `start`.
- `wdata`  in  8  write data. Latched with `start`.
- `rdata`  out  8  read data. Updated only on a successful read.
- `busy`  out  1  high from the cycle after `start` is accepted until the `done` cycle.
- `done`  out  1  one-cycle completion pulse.
- `ack_err`  out  1  valid with `done`: 1 = slave NACKed. Held until the next accepted `start`.
- `iicing`  out  1  equals `busy`. Drives DRAM `iicing`.
- `sck`  out  1  SCL, push-pull.
- `sda`  inout  1  SDA, open-drain.
  - The block only drives 0 or releases to Z.
  - High comes from the board pull-up.
  - The block reads `sda` through a 2-flop synchronizer.

## Operation
- Bit engine:
  - Each bit slot is 4 quarters of `CLK_DIV` cycles.
  - Q0: SCL low; SDA updated at Q0 entry.
  - Q1: SCL high.
  - Q2: SCL high; SDA sampled at Q2 entry.
  - Q3: SCL low.
- START slot: SDA released in Q0, SCL high in Q1, SDA driven 0 at Q2 entry, SCL low in Q3.
- Repeated-START slot: identical to the START slot.
- STOP slot: SDA 0 in Q0, SCL high in Q1, SDA released at Q2 entry, SCL stays high in Q3.
- Byte out: MSB first, 8 data slots. The 9th slot releases SDA and samples the ACK; 0 = ACK.
- Byte in: 8 slots with SDA released, sampled MSB first. In the 9th slot the master releases SDA (NACK).
- States: IDLE, START, DEVW, ACK_DW, INDEX, ACK_IX, then one of two branches:
  - rw=0: WDATA, ACK_WD, STOP, TAIL.
  - rw=1: RSTART, DEVR, ACK_DR, RDATA, MNACK, STOP, TAIL.
- TAIL is one bus-free slot with SCL=1 and SDA released. It keeps `iicing` high while DRAM commits `MemWea`. The block then pulses `done` and returns to IDLE.
- NACK in any ACK_* state:
  - Set `ack_err` and jump to STOP, then TAIL and `done`.
  - `rdata` is unchanged.
- `rdata` loads in MNACK at slot end.
- `start` while busy is ignored. No queueing.
- Reset, including mid-transaction:
  - `sck`=1, `sda` released, `busy`/`done`/`ack_err`/`iicing`=0, `rdata`=0x00, state IDLE.
  - The slave recovers on the next START.

## Timing
- `start` is accepted in cycle 0; `busy` rises in cycle 1.
- Write, no error: 1 + 27 + 1 + 1 = 30 slots. `done` is high in cycle 30·4·CLK_DIV + 1.
- Read, no error: 1 + 18 + 1 + 18 + 1 + 1 = 40 slots. `done` is high in cycle 40·4·CLK_DIV + 1.
- Error on the device-write ACK: 1 + 9 + 1 + 1 = 12 slots.
- SCL period is 4·CLK_DIV `gclk`. With CLK_DIV=50 at 50 MHz, SCL is 250 kHz.
- Minimum SDA setup to the SCL rise and hold after the SCL fall is CLK_DIV cycles. This covers DRAM's edge-detector latency.
- `sck` and `sda` output-enable are registered. There is no combinational path from inputs to pins.
- `done` and `busy` do not overlap: `busy` falls in the same cycle `done` rises.

## Configuration
- `I2C_MASTER_NACK_RETRY_EN`:
  - Defined: a NACK in ACK_DW or ACK_DR issues STOP plus TAIL, then restarts the whole transaction. Up to 3 retries, 4 attempts total.
  - `ack_err` is set only if all attempts fail. Latency grows by whole-transaction multiples.
  - A NACK on index or data never retries.
  - Undefined: no retry; the first NACK ends the transaction with `ack_err`=1.

## Test plan
- Write: CLK_DIV=4, `start`, rw=0, addr=0x10, wdata=0x5A, with DRAM attached.
  - Bus carries 0xA2, 0x10, 0x5A, all ACKed.
  - `done` at cycle 481, `ack_err`=0.
  - DRAM[0x10]=0x5A.
- Read after write: addr=0x10, rw=1.
  - Bus shows a repeated START before 0xA3.
  - `rdata`=0x5A, master NACK, `done` at cycle 641.
- Wrong address: DEV_ADDR=7'h52, no slave responds.
  - `done` at cycle 12·16+1 = 193, `ack_err`=1, `rdata` unchanged.
  - With `I2C_MASTER_NACK_RETRY_EN`: 4 attempts, `done` at cycle 4·192+1 = 769.
- `start` pulsed while busy: ignored.
  - First transaction's data unchanged.
  - Exactly one `done`.
- `rst_n` low mid-INDEX: `sck`=1, `sda`=Z and outputs 0 within the same cycle.
  - Next write of 0xC3 to 0x20 succeeds.
- Boundary values: addr=0xFF, wdata=0x00, then read back 0x00. Then addr=0x00 with 0xFF, read back 0xFF.

Source files
------------

// File: rtl/i2c_host_master_if.sv
// i2c_host_master_if: request/response bundle between on-chip logic
// and the single-byte I2C host master.
interface i2c_host_master_if;
    logic       start;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       iicing;

    modport master (
        output start, rw, addr, wdata,
        input  rdata, busy, done, ack_err, iicing
    );

    modport slave (
        input  start, rw, addr, wdata,
        output rdata, busy, done, ack_err, iicing
    );
endinterface

// File: rtl/i2c_host_master.sv
// i2c_host_master: single-byte I2C master for the DRAM slave at 0xA2/0xA3.
// Option I2C_MASTER_NACK_RETRY_EN: retry whole transaction on address NACK.
module i2c_host_master #(
    parameter int unsigned CLK_DIV  = 50,
    parameter logic [6:0]  DEV_ADDR = 7'h51
) (
    input  logic             gclk,
    input  logic             rst_n,
    i2c_host_master_if.slave bus,
    output logic             sck,
    inout  wire              sda
);
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEVW, S_ACK_DW, S_INDEX,
        S_ACK_IX, S_WDATA, S_ACK_WD, S_RSTART, S_DEVR,
        S_ACK_DR, S_RDATA, S_MNACK, S_STOP, S_TAIL
    } state_t;

    localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);

    state_t     r_state;
    logic [9:0] r_div;
    logic [1:0] r_q;
    logic [2:0] r_bit;
    logic       r_rw;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rx;
    logic [7:0] r_rdata;
    logic       r_busy;
    logic       r_done;
    logic       r_ack_err;
    logic       r_sck;
    logic       r_oe;
    logic       r_s1;
    logic       r_s2;
    logic       r_smp;
`ifdef I2C_MASTER_NACK_RETRY_EN
    logic [1:0] r_tries;
    logic       r_retry;
`endif

    logic       w_qend;
    logic       w_slot_end;
    logic       w_mid;
    logic       w_sck_nx;
    logic       w_oe_nx;
    logic [7:0] w_txb;
    state_t     w_byte_nx;

    assign w_qend     = (r_div == DIV_LAST);
    assign w_slot_end = w_qend && (r_q == 2'd3);
    assign w_mid      = (r_q == 2'd1) || (r_q == 2'd2);

    assign sda         = r_oe ? 1'b0 : 1'bz;
    assign sck         = r_sck;
    assign bus.rdata   = r_rdata;
    assign bus.busy    = r_busy;
    assign bus.iicing  = r_busy;
    assign bus.done    = r_done;
    assign bus.ack_err = r_ack_err;

    // Byte being shifted out and the slot that follows the last bit.
    always_comb begin
        w_txb     = 8'h00;
        w_byte_nx = S_IDLE;
        unique case (r_state)
            S_DEVW: begin
                w_txb     = {DEV_ADDR, 1'b0};
                w_byte_nx = S_ACK_DW;
            end
            S_INDEX: begin
                w_txb     = r_addr;
                w_byte_nx = S_ACK_IX;
            end
            S_WDATA: begin
                w_txb     = r_wdata;
                w_byte_nx = S_ACK_WD;
            end
            S_DEVR: begin
                w_txb     = {DEV_ADDR, 1'b1};
                w_byte_nx = S_ACK_DR;
            end
            S_RDATA: w_byte_nx = S_MNACK;
            default: ;
        endcase
    end

    // Pin levels for the current slot and quarter.
    always_comb begin
        w_sck_nx = w_mid;
        w_oe_nx  = 1'b0;
        unique case (r_state)
            S_IDLE, S_TAIL: w_sck_nx = 1'b1;
            S_START, S_RSTART: w_oe_nx = r_q[1];
            S_STOP: begin
                w_sck_nx = (r_q != 2'd0);
                w_oe_nx  = ~r_q[1];
            end
            S_DEVW, S_INDEX, S_WDATA, S_DEVR:
                w_oe_nx = ~w_txb[r_bit];
            default: ;
        endcase
    end

    // Slot timing, transaction sequencing and registered pin drive.
    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_div     <= 10'd0;
            r_q       <= 2'd0;
            r_bit     <= 3'd7;
            r_rw      <= 1'b0;
            r_addr    <= 8'h00;
            r_wdata   <= 8'h00;
            r_rx      <= 8'h00;
            r_rdata   <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_sck     <= 1'b1;
            r_oe      <= 1'b0;
            r_s1      <= 1'b1;
            r_s2      <= 1'b1;
            r_smp     <= 1'b1;
`ifdef I2C_MASTER_NACK_RETRY_EN
            r_tries   <= 2'd0;
            r_retry   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_sck  <= w_sck_nx;
            r_oe   <= w_oe_nx;
            r_s1   <= sda;
            r_s2   <= r_s1;
            if (r_state == S_IDLE) begin
                if (bus.start) begin
                    r_state   <= S_START;
                    r_busy    <= 1'b1;
                    r_ack_err <= 1'b0;
                    r_rw      <= bus.rw;
                    r_addr    <= bus.addr;
                    r_wdata   <= bus.wdata;
                    r_div     <= 10'd0;
                    r_q       <= 2'd0;
                    r_bit     <= 3'd7;
`ifdef I2C_MASTER_NACK_RETRY_EN
                    r_tries   <= 2'd0;
                    r_retry   <= 1'b0;
`endif
                end
            end else begin
                r_div <= w_qend ? 10'd0 : r_div + 10'd1;
                if (w_qend) begin
                    r_q <= r_q + 2'd1;
                end
                if (w_qend && (r_q == 2'd1)) begin
                    r_smp <= r_s2;
                    if (r_state == S_RDATA) begin
                        r_rx <= {r_rx[6:0], r_s2};
                    end
                end
                if (w_slot_end) begin
                    unique case (r_state)
                        S_START: r_state <= S_DEVW;
                        S_DEVW, S_INDEX, S_WDATA, S_DEVR, S_RDATA: begin
                            r_bit <= r_bit - 3'd1;
                            if (r_bit == 3'd0) begin
                                r_state <= w_byte_nx;
                            end
                        end
                        S_ACK_DW, S_ACK_DR: begin
                            if (r_smp) begin
                                r_state <= S_STOP;
`ifdef I2C_MASTER_NACK_RETRY_EN
                                if (r_tries == 2'd3) begin
                                    r_ack_err <= 1'b1;
                                end else begin
                                    r_retry <= 1'b1;
                                    r_tries <= r_tries + 2'd1;
                                end
`else
                                r_ack_err <= 1'b1;
`endif
                            end else begin
                                r_state <= (r_state == S_ACK_DW) ?
                                           S_INDEX : S_RDATA;
                            end
                        end
                        S_ACK_IX: begin
                            if (r_smp) begin
                                r_ack_err <= 1'b1;
                                r_state   <= S_STOP;
                            end else begin
                                r_state <= r_rw ? S_RSTART : S_WDATA;
                            end
                        end
                        S_ACK_WD: begin
                            r_ack_err <= r_smp;
                            r_state   <= S_STOP;
                        end
                        S_RSTART: r_state <= S_DEVR;
                        S_MNACK: begin
                            r_rdata <= r_rx;
                            r_state <= S_STOP;
                        end
                        S_STOP: r_state <= S_TAIL;
                        S_TAIL: begin
`ifdef I2C_MASTER_NACK_RETRY_EN
                            if (r_retry) begin
                                r_retry <= 1'b0;
                                r_state <= S_START;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
`else
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
`endif
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_host_master.sv
// tb_i2c_host_master: random and directed transactions against a
// behavioural DRAM-style I2C slave and a transaction-level model.
module tb_i2c_host_master;
    localparam int CD   = 4;
    localparam int SLOT = 4 * CD;

    logic gclk = 1'b0;
    logic rst_n = 1'b0;
    logic sck;
    wire  sda;
    logic s_drv = 1'b0;

    always #5 gclk = ~gclk;

    i2c_host_master_if bus ();

    pullup (sda);
    assign sda = s_drv ? 1'b0 : 1'bz;

    i2c_host_master #(.CLK_DIV(CD), .DEV_ADDR(7'h51)) dut (
        .gclk  (gclk),
        .rst_n (rst_n),
        .bus   (bus),
        .sck   (sck),
        .sda   (sda)
    );

    int n_chk  = 0;
    int n_pass = 0;

    bit          absent  = 1'b0;
    bit          nack_ix = 1'b0;
    logic [7:0]  s_mem [256];
    logic [7:0]  m_mem [256];
    logic [7:0]  m_rdata = 8'h00;
    byte unsigned s_bytes [$];
    int          s_starts = 0;
    int          s_mnack  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Byte-level slave: 0xA2 write / 0xA3 read, index then data.
    initial begin : slave
        logic ps, pd, c, d, mn;
        logic [7:0] sh, ptr, rb, aw;
        int ph, cnt;
        ps = 1'b1; pd = 1'b1; mn = 1'b1;
        sh = 8'h00; ptr = 8'h00; rb = 8'h00;
        ph = 0; cnt = 0;
        forever begin
            @(negedge gclk);
            c  = sck;
            d  = sda;
            aw = absent ? 8'hA4 : 8'hA2;
            if (ps && c && pd && !d) begin
                ph = 1; cnt = 0; sh = 8'h00; s_drv = 1'b0;
                s_starts++;
            end else if (ps && c && !pd && d) begin
                ph = 0; s_drv = 1'b0;
            end else if (!ps && c && ph != 0) begin
                cnt++;
                if (cnt <= 8 && ph <= 3) sh = {sh[6:0], d};
                if (ph == 4 && cnt == 9) begin
                    mn = d;
                    if (d) s_mnack++;
                end
            end else if (ps && !c && ph != 0) begin
                if (cnt == 8 && ph <= 3) begin
                    s_bytes.push_back(sh);
                    if (ph == 1) begin
                        if (sh == aw) begin
                            ph = 2; s_drv = 1'b1;
                        end else if (sh == (aw | 8'h01)) begin
                            ph = 5; s_drv = 1'b1;
                        end else begin
                            ph = 0;
                        end
                    end else if (ph == 2) begin
                        ptr = sh;
                        s_drv = !nack_ix;
                        ph = nack_ix ? 0 : 3;
                    end else begin
                        s_mem[ptr] = sh;
                        ptr++;
                        s_drv = 1'b1;
                    end
                end else if (cnt == 9) begin
                    s_drv = 1'b0; cnt = 0; sh = 8'h00;
                    if (ph == 4) begin
                        if (mn) ph = 0;
                        else ptr++;
                    end
                    if (ph == 5) ph = 4;
                    if (ph == 4) begin
                        rb = s_mem[ptr];
                        s_drv = ~rb[7];
                    end
                end else if (ph == 4 && cnt >= 1 && cnt <= 7) begin
                    s_drv = ~rb[3'(7 - cnt)];
                end else if (ph == 4 && cnt == 8) begin
                    s_drv = 1'b0;
                end
            end
            ps = c;
            pd = d;
        end
    end

    task automatic run(input logic rw_i, input logic [7:0] a,
                       input logic [7:0] wd, input int poke);
        int n, ndone, slots, att, exp_st, exp_mn;
        logic err;
        byte unsigned eb [$];
        att = 1; exp_mn = 0;
        if (absent) begin
`ifdef I2C_MASTER_NACK_RETRY_EN
            att = 4;
`endif
            slots = 12 * att; err = 1'b1; exp_st = att;
            repeat (att) eb.push_back(8'hA2);
        end else if (nack_ix) begin
            slots = 21; err = 1'b1; exp_st = 1;
            eb.push_back(8'hA2); eb.push_back(a);
        end else if (!rw_i) begin
            slots = 30; err = 1'b0; exp_st = 1;
            eb.push_back(8'hA2); eb.push_back(a); eb.push_back(wd);
            m_mem[a] = wd;
        end else begin
            slots = 40; err = 1'b0; exp_st = 2; exp_mn = 1;
            eb.push_back(8'hA2); eb.push_back(a); eb.push_back(8'hA3);
            m_rdata = m_mem[a];
        end
        s_bytes.delete(); s_starts = 0; s_mnack = 0;
        @(negedge gclk);
        bus.start = 1'b1; bus.rw = rw_i; bus.addr = a; bus.wdata = wd;
        @(posedge gclk); #1;
        bus.start = 1'b0; bus.addr = ~a; bus.wdata = ~wd;
        check("busy_c1", bus.busy, 1);
        check("iicing_c1", bus.iicing, 1);
        n = 1; ndone = 0;
        while (!bus.done && n < 4000) begin
            @(posedge gclk); #1;
            n++;
            bus.start = (n == poke);
        end
        bus.start = 1'b0;
        check("done_cycle", n, slots * SLOT + 1);
        check("busy_at_done", bus.busy, 0);
        check("ack_err", bus.ack_err, err);
        check("rdata", bus.rdata, m_rdata);
        repeat (4 * SLOT) begin
            @(posedge gclk); #1;
            if (bus.done) ndone++;
        end
        check("extra_done", ndone, 0);
        check("idle_busy", bus.busy, 0);
        check("ack_err_hold", bus.ack_err, err);
        check("starts", s_starts, exp_st);
        check("mnack", s_mnack, exp_mn);
        check("nbytes", s_bytes.size(), eb.size());
        for (int i = 0; i < int'(eb.size()) && i < int'(s_bytes.size()); i++)
            check("bus_byte", s_bytes[i], eb[i]);
        check("mem", s_mem[a], m_mem[a]);
        check("mem_other", s_mem[~a], m_mem[~a]);
    endtask

    task automatic idle_checks(input string tag);
        check({tag, "_sck"}, sck, 1);
        check({tag, "_sda"}, sda, 1);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_ack_err"}, bus.ack_err, 0);
        check({tag, "_iicing"}, bus.iicing, 0);
        check({tag, "_rdata"}, bus.rdata, 0);
    endtask

    task automatic reset_mid();
        @(negedge gclk);
        bus.start = 1'b1; bus.rw = 1'b0;
        bus.addr = 8'h33; bus.wdata = 8'h99;
        @(posedge gclk); #1;
        bus.start = 1'b0;
        repeat (12 * SLOT - 5) @(posedge gclk);
        @(negedge gclk);
        rst_n = 1'b0;
        #1;
        idle_checks("rst_mid");
        m_rdata = 8'h00;
        @(negedge gclk);
        rst_n = 1'b1;
        repeat (SLOT) @(posedge gclk);
        check("abort_mem", s_mem[8'h33], m_mem[8'h33]);
    endtask

    initial begin
        logic [7:0] ra, rd;
        logic rrw;
        bus.start = 1'b0; bus.rw = 1'b0;
        bus.addr = 8'h00; bus.wdata = 8'h00;
        for (int i = 0; i < 256; i++) begin
            s_mem[i] = 8'(i * 37 + 5);
            m_mem[i] = 8'(i * 37 + 5);
        end
        repeat (3) @(posedge gclk);
        #1;
        idle_checks("reset");
        @(negedge gclk);
        rst_n = 1'b1;
        repeat (4) @(posedge gclk);

        run(1'b0, 8'h10, 8'h5A, 0);
        run(1'b1, 8'h10, 8'h00, 0);
        absent = 1'b1;
        run(1'b1, 8'h10, 8'h00, 0);
        absent = 1'b0;
        run(1'b0, 8'h44, 8'h77, 100);
        run(1'b1, 8'h44, 8'h00, 200);
        reset_mid();
        run(1'b0, 8'h20, 8'hC3, 0);
        run(1'b1, 8'h20, 8'h00, 0);
        run(1'b0, 8'hFF, 8'h00, 0);
        run(1'b1, 8'hFF, 8'h00, 0);
        run(1'b0, 8'h00, 8'hFF, 0);
        run(1'b1, 8'h00, 8'h00, 0);
        nack_ix = 1'b1;
        run(1'b0, 8'h55, 8'h66, 0);
        nack_ix = 1'b0;

        for (int k = 0; k < 14; k++) begin
            rrw = 1'($urandom_range(0, 1));
            ra  = 8'($urandom);
            rd  = 8'($urandom);
            absent = ($urandom_range(0, 7) == 0);
            run(rrw, ra, rd, int'($urandom_range(0, 300)));
            absent = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
